serial_receiver: RTL and testbench
==================================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, giving Clk cycles per serial bit; legal values are even and >= 2.
REQ-002 SHALL have parameter FRAME_BITS, default 32, giving the payload width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be, clock and reset first:
- Clk  input  1: sole clock; all state changes on the rising edge.
- Reset  input  1: asynchronous, active-low reset.
- Din  input  1: serial line; idles high.
- DataOut  output  FRAME_BITS: last good received word.
- RxDone  output  1: one-cycle pulse when DataOut is updated.
- RxBusy  output  1: high while a frame is in progress.
- FrameErr  output  1: one-cycle pulse on a bad stop bit.

Function
REQ-005 Frame format SHALL be: idle 1, start bit 0, FRAME_BITS data bits MSB first, stop bit 1; each bit lasts CLK_DIV Clk cycles.
REQ-006 Din SHALL pass through a 2-flop synchronizer before any use (signal din_s).
REQ-007 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-008 IDLE: when din_s is 0, SHALL go to START and load the bit counter with CLK_DIV/2-1.
REQ-009 START: when the counter expires (mid start bit), SHALL resample din_s.
- If 1: treat as a glitch and return to IDLE with no pulse.
- If 0: go to DATA with bit index FRAME_BITS-1 and the counter reloaded to CLK_DIV-1.
REQ-010 DATA: on each counter expiry SHALL shift din_s into the shift register LSB (MSB-first assembly) and reload the counter; after the last bit, go to STOP.
REQ-011 STOP: on counter expiry, if din_s is 1, SHALL load DataOut from the shift register and pulse RxDone for exactly 1 cycle, both in the same cycle.
REQ-012 STOP: if din_s is 0 at expiry, SHALL pulse FrameErr for 1 cycle and leave DataOut unchanged.
REQ-013 After STOP the FSM SHALL return to IDLE; a start bit that immediately follows the stop bit SHALL be accepted with no dead cycle beyond the IDLE detection cycle.
REQ-014 Latency: RxDone SHALL rise exactly 3 + CLK_DIV/2 + (FRAME_BITS+1)*CLK_DIV Clk cycles after the first rising edge at which Din is sampled 0; with defaults this is 70 cycles.
REQ-015 RxBusy SHALL be 1 in START, DATA and STOP, and 0 in IDLE, including the cycle in which RxDone or FrameErr pulses.
REQ-016 RxDone and FrameErr SHALL never both be 1 in the same cycle.
REQ-017 The bit counter SHALL be $clog2(CLK_DIV) bits wide and the bit index $clog2(FRAME_BITS) bits wide; the index SHALL not wrap within a frame.

Reset
REQ-018 Reset low SHALL immediately force: FSM to IDLE, DataOut=0, RxDone=0, RxBusy=0, FrameErr=0, shift register and counters=0, synchronizer flops=1.
REQ-019 Reset asserted mid-frame SHALL discard the partial frame with no pulse; after release, reception SHALL resume only on a fresh start bit.

Structure
REQ-020 Package serial_pkg SHALL hold the FSM state enum, FRAME_BITS_DEF=32 and CLK_DIV_DEF=2; the package is shared with the transmitter.
REQ-021 Bit timing SHALL live in one sub-module, bit_timer: a loadable down-counter with an expiry pulse, instantiated once.

Verification
REQ-022 Reset, then send 0x12345678 with a valid stop bit -> DataOut=0x12345678, RxDone one pulse 70 cycles after the start edge, FrameErr never asserted.
REQ-023 Send 0xA5A5A5A5 then 0xFFFFFFFF back-to-back (no idle gap) -> two RxDone pulses 68 cycles apart, with DataOut correct after each.
REQ-024 Send 0xDEADBEEF with stop bit 0 -> FrameErr one pulse, RxDone 0, DataOut keeps its previous value.
REQ-025 1-cycle low glitch on idle Din -> FSM returns to IDLE after the START check, no pulses, RxBusy high for at most 2 cycles.
REQ-026 Reset asserted at data bit 10 of a frame, then a new frame 0x00000001 -> outputs zero during reset, single RxDone, DataOut=0x00000001.
REQ-027 Repeat REQ-022 with CLK_DIV=8 -> DataOut=0x12345678, RxDone at 3+4+33*8 = 271 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// serial_pkg : shared state encoding and defaults for the serial link
// Revision   : 1.0
// ============================================================================
package serial_pkg;

  localparam int FRAME_BITS_DEF = 32;
  localparam int CLK_DIV_DEF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
// bit_timer : loadable down-counter, o_expire is high while the count is zero
// Revision  : 1.0
// ============================================================================
module bit_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expire
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Loading val gives an expiry val+1 cycles later; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/serial_receiver.sv
`default_nettype none
// ============================================================================
// serial_receiver : start/data(MSB first)/stop frame receiver, registered outputs
// Revision        : 1.0
// ============================================================================
module serial_receiver
  import serial_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Din,
  output logic [FRAME_BITS-1:0] DataOut,
  output logic                  RxDone,
  output logic                  RxBusy,
  output logic                  FrameErr
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] c_half_load = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] c_bit_load  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] c_last_idx  = IW'(FRAME_BITS - 1);

  logic [1:0]            sync_q,     sync_d;
  rx_state_t             state_q,    state_d;
  logic [FRAME_BITS-1:0] shift_q,    shift_d;
  logic [IW-1:0]         idx_q,      idx_d;
  logic                  stop_ok_q,  stop_ok_d;
  logic                  stop_bad_q, stop_bad_d;
  logic [FRAME_BITS-1:0] data_out_q, data_out_d;
  logic                  rx_done_q,  rx_done_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_busy_q,  rx_busy_d;

  logic                  din_s;
  logic                  timer_load;
  logic [CW-1:0]         timer_val;
  logic                  timer_expire;

  assign din_s = sync_q[1];

  bit_timer #(
    .WIDTH (CW)
  ) u_bit_timer (
    .clk        (Clk),
    .rst_n      (Reset),
    .i_load     (timer_load),
    .i_load_val (timer_val),
    .o_expire   (timer_expire)
  );

  always_comb begin
    sync_d     = {sync_q[0], Din};
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_ok_d  = 1'b0;
    stop_bad_d = 1'b0;
    timer_load = 1'b0;
    timer_val  = c_bit_load;

    case (state_q)
      ST_IDLE: begin
        if (!din_s) begin
          state_d    = ST_START;
          timer_load = 1'b1;
          timer_val  = c_half_load;
        end
      end
      ST_START: begin
        // Mid start bit: a line that is high again was only a glitch.
        if (timer_expire) begin
          if (din_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_DATA;
            idx_d      = c_last_idx;
            timer_load = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (timer_expire) begin
          shift_d    = {shift_q[FRAME_BITS-2:0], din_s};
          timer_load = 1'b1;
          if (idx_q == '0) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (timer_expire) begin
          state_d    = ST_IDLE;
          stop_ok_d  = din_s;
          stop_bad_d = !din_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs lag the FSM by one register stage; shift_q is still intact
    // because IDLE and START never touch it.
    rx_done_d   = stop_ok_q;
    frame_err_d = stop_bad_q;
    rx_busy_d   = (state_q != ST_IDLE);
    data_out_d  = stop_ok_q ? shift_q : data_out_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      stop_ok_q   <= 1'b0;
      stop_bad_q  <= 1'b0;
      data_out_q  <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      stop_ok_q   <= stop_ok_d;
      stop_bad_q  <= stop_bad_d;
      data_out_q  <= data_out_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign DataOut  = data_out_q;
  assign RxDone   = rx_done_q;
  assign RxBusy   = rx_busy_q;
  assign FrameErr = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_receiver.sv
`default_nettype none
// ============================================================================
// tb_serial_receiver : randomized and directed frames against a frame-level model
// Revision           : 1.0
// ============================================================================
module tb_serial_receiver;

  localparam int FB = 32;
  localparam int D1 = 2;
  localparam int D8 = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          din1  = 1'b1;
  logic          din8  = 1'b1;
  logic [FB-1:0] dout1, dout8;
  logic          done1, done8, busy1, busy8, err1, err8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int            done_cyc1[$];
  logic [FB-1:0] done_dat1[$];
  int            err_cyc1[$];
  int            done_cyc8[$];
  logic [FB-1:0] done_dat8[$];
  int            err_cyc8[$];
  int            busy_cnt1 = 0;
  int            both_cnt  = 0;

  // Frame-level model state: last good word seen by each receiver.
  logic [FB-1:0] model1, model8;

  serial_receiver #(.CLK_DIV(D1), .FRAME_BITS(FB)) dut1 (
    .Clk(clk), .Reset(rst_n), .Din(din1), .DataOut(dout1),
    .RxDone(done1), .RxBusy(busy1), .FrameErr(err1));

  serial_receiver #(.CLK_DIV(D8), .FRAME_BITS(FB)) dut8 (
    .Clk(clk), .Reset(rst_n), .Din(din8), .DataOut(dout8),
    .RxDone(done8), .RxBusy(busy8), .FrameErr(err8));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done1) begin done_cyc1.push_back(cyc); done_dat1.push_back(dout1); end
    if (err1)  err_cyc1.push_back(cyc);
    if (done8) begin done_cyc8.push_back(cyc); done_dat8.push_back(dout8); end
    if (err8)  err_cyc8.push_back(cyc);
    if (busy1) busy_cnt1 <= busy_cnt1 + 1;
    if ((done1 && err1) || (done8 && err8)) both_cnt <= both_cnt + 1;
  end

  function automatic int lat(input int d);
    return 3 + d / 2 + (FB + 1) * d;
  endfunction

  task automatic set_din(input int which, input logic b);
    if (which == 8) din8 = b; else din1 = b;
  endtask

  // start_cyc is the cycle count seen just after the edge that first samples the start bit.
  task automatic send(input int which, input logic [FB-1:0] w, input logic stop,
                      input int ndata, output int start_cyc);
    int d;
    d = (which == 8) ? D8 : D1;
    @(negedge clk); set_din(which, 1'b0); start_cyc = cyc + 1;
    repeat (d - 1) @(negedge clk);
    for (int i = 0; i < ndata; i++) begin
      @(negedge clk); set_din(which, w[FB-1-i]);
      repeat (d - 1) @(negedge clk);
    end
    if (ndata == FB) begin
      @(negedge clk); set_din(which, stop);
      repeat (d - 1) @(negedge clk);
    end
  endtask

  task automatic gap(input int which, input int n);
    if (n > 0) begin
      @(negedge clk); set_din(which, 1'b1);
      repeat (n - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din1 = 1'b1; din8 = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (dout1 !== '0)  begin bad++; $display("FAIL reset_dataout got=%h want=0", dout1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_rxdone got=%b want=0", done1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_rxbusy got=%b want=0", busy1); end
    total++; if (err1 !== 1'b0)  begin bad++; $display("FAIL reset_frameerr got=%b want=0", err1); end
    total++; if (dout8 !== '0)  begin bad++; $display("FAIL reset_dataout8 got=%h want=0", dout8); end
    rst_n = 1'b1;
    model1 = '0; model8 = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int n0, e0, s;
    n0 = done_cyc1.size(); e0 = err_cyc1.size();
    send(1, 32'h1234_5678, 1'b1, FB, s);
    gap(1, 10);
    model1 = 32'h1234_5678;
    total++; if (done_cyc1.size() - n0 != 1) begin bad++; $display("FAIL single_count got=%0d want=1", done_cyc1.size() - n0); end
    else begin
      total++; if (done_cyc1[n0] != s + lat(D1)) begin bad++; $display("FAIL single_latency got=%0d want=%0d", done_cyc1[n0] - s, lat(D1)); end
      total++; if (done_dat1[n0] !== model1) begin bad++; $display("FAIL single_data got=%h want=%h", done_dat1[n0], model1); end
    end
    total++; if (err_cyc1.size() != e0) begin bad++; $display("FAIL single_frameerr got=%0d want=0", err_cyc1.size() - e0); end
    total++; if (dout1 !== model1) begin bad++; $display("FAIL single_hold got=%h want=%h", dout1, model1); end
  endtask

  task automatic test_back_to_back();
    int n0, s0, s1;
    n0 = done_cyc1.size();
    send(1, 32'hA5A5_A5A5, 1'b1, FB, s0);
    send(1, 32'hFFFF_FFFF, 1'b1, FB, s1);
    gap(1, 10);
    model1 = 32'hFFFF_FFFF;
    total++; if (done_cyc1.size() - n0 != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", done_cyc1.size() - n0); end
    else begin
      total++; if (done_cyc1[n0] != s0 + lat(D1)) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", done_cyc1[n0] - s0, lat(D1)); end
      total++; if (done_cyc1[n0+1] - done_cyc1[n0] != (FB + 2) * D1) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", done_cyc1[n0+1] - done_cyc1[n0], (FB + 2) * D1); end
      total++; if (done_dat1[n0] !== 32'hA5A5_A5A5) begin bad++; $display("FAIL b2b_data0 got=%h want=a5a5a5a5", done_dat1[n0]); end
      total++; if (done_dat1[n0+1] !== model1) begin bad++; $display("FAIL b2b_data1 got=%h want=%h", done_dat1[n0+1], model1); end
    end
  endtask

  task automatic test_frame_error();
    int n0, e0, s;
    n0 = done_cyc1.size(); e0 = err_cyc1.size();
    send(1, 32'hDEAD_BEEF, 1'b0, FB, s);
    gap(1, 12);
    total++; if (err_cyc1.size() - e0 != 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", err_cyc1.size() - e0); end
    else begin
      total++; if (err_cyc1[e0] != s + lat(D1)) begin bad++; $display("FAIL ferr_latency got=%0d want=%0d", err_cyc1[e0] - s, lat(D1)); end
    end
    total++; if (done_cyc1.size() != n0) begin bad++; $display("FAIL ferr_rxdone got=%0d want=0", done_cyc1.size() - n0); end
    total++; if (dout1 !== model1) begin bad++; $display("FAIL ferr_dataout got=%h want=%h", dout1, model1); end
  endtask

  task automatic test_glitch();
    int n0, e0, b0;
    n0 = done_cyc1.size(); e0 = err_cyc1.size(); b0 = busy_cnt1;
    @(negedge clk); din1 = 1'b0;
    @(negedge clk); din1 = 1'b1;
    repeat (15) @(negedge clk);
    total++; if (busy_cnt1 - b0 < 1 || busy_cnt1 - b0 > 2) begin bad++; $display("FAIL glitch_busy_cycles got=%0d want=1..2", busy_cnt1 - b0); end
    total++; if (done_cyc1.size() != n0 || err_cyc1.size() != e0) begin bad++; $display("FAIL glitch_pulses got=%0d/%0d want=0/0", done_cyc1.size() - n0, err_cyc1.size() - e0); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", busy1); end
    total++; if (dout1 !== model1) begin bad++; $display("FAIL glitch_dataout got=%h want=%h", dout1, model1); end
  endtask

  task automatic test_reset_mid_frame();
    int n0, e0, s;
    n0 = done_cyc1.size(); e0 = err_cyc1.size();
    send(1, 32'hCAFE_F00D, 1'b1, 10, s);
    @(negedge clk); rst_n = 1'b0; din1 = 1'b1;
    #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy1); end
    total++; if (dout1 !== '0) begin bad++; $display("FAIL rst_mid_dataout got=%h want=0", dout1); end
    total++; if (done1 !== 1'b0 || err1 !== 1'b0) begin bad++; $display("FAIL rst_mid_pulses got=%b%b want=00", done1, err1); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model1 = '0; model8 = '0;
    repeat (10) @(negedge clk);
    send(1, 32'h0000_0001, 1'b1, FB, s);
    gap(1, 10);
    model1 = 32'h0000_0001;
    total++; if (done_cyc1.size() - n0 != 1) begin bad++; $display("FAIL rst_mid_count got=%0d want=1", done_cyc1.size() - n0); end
    else begin
      total++; if (done_dat1[n0] !== model1) begin bad++; $display("FAIL rst_mid_data got=%h want=%h", done_dat1[n0], model1); end
      total++; if (done_cyc1[n0] != s + lat(D1)) begin bad++; $display("FAIL rst_mid_latency got=%0d want=%0d", done_cyc1[n0] - s, lat(D1)); end
    end
    total++; if (err_cyc1.size() != e0) begin bad++; $display("FAIL rst_mid_frameerr got=%0d want=0", err_cyc1.size() - e0); end
  endtask

  task automatic test_random();
    int            n0, e0, s, g;
    logic [FB-1:0] w;
    logic          stop;
    int            exp_dc[$];
    logic [FB-1:0] exp_dd[$];
    int            exp_ec[$];
    n0 = done_cyc1.size(); e0 = err_cyc1.size();
    for (int f = 0; f < 8; f++) begin
      w    = $urandom;
      stop = ($urandom_range(0, 3) != 0);
      send(1, w, stop, FB, s);
      if (stop) begin
        model1 = w;
        exp_dc.push_back(s + lat(D1));
        exp_dd.push_back(w);
        g = $urandom_range(0, 3);
      end else begin
        exp_ec.push_back(s + lat(D1));
        g = 8;
      end
      gap(1, g);
    end
    gap(1, 10);
    total++; if (done_cyc1.size() - n0 != exp_dc.size()) begin bad++; $display("FAIL rand_done_count got=%0d want=%0d", done_cyc1.size() - n0, exp_dc.size()); end
    else begin
      for (int k = 0; k < exp_dc.size(); k++) begin
        total++; if (done_cyc1[n0+k] != exp_dc[k] || done_dat1[n0+k] !== exp_dd[k]) begin
          bad++; $display("FAIL rand_done[%0d] got=%0d/%h want=%0d/%h", k, done_cyc1[n0+k], done_dat1[n0+k], exp_dc[k], exp_dd[k]);
        end
      end
    end
    total++; if (err_cyc1.size() - e0 != exp_ec.size()) begin bad++; $display("FAIL rand_err_count got=%0d want=%0d", err_cyc1.size() - e0, exp_ec.size()); end
    else begin
      for (int k = 0; k < exp_ec.size(); k++) begin
        total++; if (err_cyc1[e0+k] != exp_ec[k]) begin bad++; $display("FAIL rand_err[%0d] got=%0d want=%0d", k, err_cyc1[e0+k], exp_ec[k]); end
      end
    end
    total++; if (dout1 !== model1) begin bad++; $display("FAIL rand_dataout got=%h want=%h", dout1, model1); end
  endtask

  task automatic test_clkdiv8();
    int n0, e0, s;
    n0 = done_cyc8.size(); e0 = err_cyc8.size();
    send(8, 32'h1234_5678, 1'b1, FB, s);
    gap(8, 20);
    model8 = 32'h1234_5678;
    total++; if (done_cyc8.size() - n0 != 1) begin bad++; $display("FAIL div8_count got=%0d want=1", done_cyc8.size() - n0); end
    else begin
      total++; if (done_cyc8[n0] != s + lat(D8)) begin bad++; $display("FAIL div8_latency got=%0d want=%0d", done_cyc8[n0] - s, lat(D8)); end
      total++; if (done_dat8[n0] !== model8) begin bad++; $display("FAIL div8_data got=%h want=%h", done_dat8[n0], model8); end
    end
    total++; if (err_cyc8.size() != e0) begin bad++; $display("FAIL div8_frameerr got=%0d want=0", err_cyc8.size() - e0); end
    total++; if (dout8 !== model8) begin bad++; $display("FAIL div8_dataout got=%h want=%h", dout8, model8); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    test_clkdiv8();
    total++; if (both_cnt != 0) begin bad++; $display("FAIL done_and_err_together got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
